// File: rtl/rgb_hue_decoder_if.sv
// Request/result bundle for the RGB-to-hue decoder.
// The bus master drives a packed colour, and the decoder returns hue and amplitude.
interface rgb_hue_decoder_if #(
  parameter int W = 6,
  parameter int D = 10
);
  logic             start;
  logic [23:0]      rgb;
  logic             ready;
  logic [D-1:0]     noteHue_o;
  logic [W+D-1:0]   noteAmplitude_o;
  logic             data_v;

  modport master (
    output start, rgb,
    input  ready, noteHue_o, noteAmplitude_o, data_v
  );

  modport slave (
    input  start, rgb,
    output ready, noteHue_o, noteAmplitude_o, data_v
  );
endinterface

// File: rtl/rgb_hue_decoder.sv
// Recovers the D-bit hue and the W.D amplitude from a packed RGB word.
// It uses an iterative restoring divider and has a fixed latency of D+3 cycles.
//
// state | meaning
// IDLE  | ready, waiting for start
// PREP  | max/min/delta, sector and numerator from captured rgb
// DIV   | one quotient bit per cycle, down-counter from D-1 to 0
// SCALE | hue = sector.f * 1/6, amplitude from max, outputs registered
// DONE  | data_v high for this one cycle
module rgb_hue_decoder #(
  parameter int W      = 6,
  parameter int D      = 10,
  parameter int invSix = 171
) (
  input  logic             clk,
  input  logic             rst,
  rgb_hue_decoder_if.slave bus
);

  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int KW = $clog2(invSix + 1);
  localparam int PW = D + 3 + KW;
  localparam int HW = PW - D;
  localparam logic [HW-1:0] HUE_MAX = HW'((1 << D) - 1);

  typedef enum logic [2:0] {IDLE, PREP, DIV, SCALE, DONE} state_t;

  state_t          state;
  logic [23:0]     rgb_q;
  logic [2:0]      sector_q;
  logic [7:0]      delta_q;
  logic [7:0]      max_q;
  logic [8:0]      rem_q;
  logic [D-1:0]    quo_q;
  logic [CW-1:0]   cnt_q;
  logic [D-1:0]    hue_q;
  logic [W+D-1:0]  amp_q;
  logic            data_v_q;

  logic [7:0]      r_c, g_c, b_c, max_c, min_c, num_c;
  logic [2:0]      sector_c;

  always_comb begin
    r_c      = rgb_q[23:16];
    g_c      = rgb_q[15:8];
    b_c      = rgb_q[7:0];
    max_c    = '0;
    num_c    = '0;
    sector_c = '0;
    // Ties resolve toward R, then G, so a grey input always lands on the R branch.
    if (r_c >= g_c && r_c >= b_c) begin
      max_c = r_c;
      if (g_c >= b_c) begin
        sector_c = 3'd0;
        num_c    = g_c - b_c;
      end else begin
        sector_c = 3'd5;
        num_c    = r_c - b_c;
      end
    end else if (g_c >= b_c) begin
      max_c = g_c;
      if (r_c > b_c) begin
        sector_c = 3'd1;
        num_c    = g_c - r_c;
      end else begin
        sector_c = 3'd2;
        num_c    = b_c - r_c;
      end
    end else begin
      max_c = b_c;
      if (g_c > r_c) begin
        sector_c = 3'd3;
        num_c    = b_c - g_c;
      end else begin
        sector_c = 3'd4;
        num_c    = r_c - g_c;
      end
    end
    if (r_c <= g_c && r_c <= b_c)
      min_c = r_c;
    else if (g_c <= b_c)
      min_c = g_c;
    else
      min_c = b_c;
  end

  logic [9:0]      shift_c, diff_c;
  logic            ge_c;
  logic [8:0]      rem_nxt;
  logic [D-1:0]    quo_nxt;

  // When num == delta, every step subtracts, so the quotient saturates at all ones.
  always_comb begin
    shift_c = {rem_q, 1'b0};
    diff_c  = shift_c - {2'b00, delta_q};
    ge_c    = (shift_c >= {2'b00, delta_q});
    rem_nxt = ge_c ? 9'(diff_c) : 9'(shift_c);
    quo_nxt = {quo_q[D-2:0], ge_c};
  end

  logic            grey_c;
  logic [D-1:0]    f_c;
  logic [2:0]      sec_s;
  logic [D+2:0]    sum_c;
  logic [PW-1:0]   prod_c;
  logic [HW-1:0]   hue_full;
  logic [D-1:0]    hue_c;
  logic [D-1:0]    maxd_c;

  always_comb begin
    grey_c   = (delta_q == 8'd0);
    f_c      = grey_c ? '0 : quo_q;
    sec_s    = grey_c ? '0 : sector_q;
    sum_c    = {sec_s, f_c};
    prod_c   = PW'(sum_c) * PW'(invSix);
    hue_full = HW'(prod_c >> D);
    hue_c    = (hue_full > HUE_MAX) ? '1 : hue_full[D-1:0];
    // Replicating the top bits of max makes 0xFF map exactly to 2^D-1.
    maxd_c   = D'({max_q, max_q} >> (16 - D));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rgb_q    <= '0;
      sector_q <= '0;
      delta_q  <= '0;
      max_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      hue_q    <= '0;
      amp_q    <= '0;
      data_v_q <= 1'b0;
    end else begin
      data_v_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rgb_q <= bus.rgb;
            state <= PREP;
          end
        end
        PREP: begin
          sector_q <= sector_c;
          delta_q  <= max_c - min_c;
          max_q    <= max_c;
          rem_q    <= {1'b0, num_c};
          quo_q    <= '0;
          cnt_q    <= CW'(D - 1);
          state    <= DIV;
        end
        DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          if (cnt_q == '0)
            state <= SCALE;
          else
            cnt_q <= cnt_q - 1'b1;
        end
        SCALE: begin
          hue_q    <= hue_c;
          amp_q    <= {{W{1'b0}}, maxd_c};
          data_v_q <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready           = (state == IDLE);
  assign bus.noteHue_o       = hue_q;
  assign bus.noteAmplitude_o = amp_q;
  assign bus.data_v          = data_v_q;

endmodule

// File: tb/tb_rgb_hue_decoder.sv
// Self-checking bench for rgb_hue_decoder. A queue holds each expected result and its due cycle,
// and a monitor compares them whenever data_v pulses.
module tb_rgb_hue_decoder;
  localparam int W       = 6;
  localparam int D       = 10;
  localparam int INV_SIX = 171;
  localparam int LAT     = D + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  rgb_hue_decoder_if #(.W(W), .D(D)) bus();

  rgb_hue_decoder #(.W(W), .D(D), .invSix(INV_SIX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    hue;
    int    amp;
    int    due;
    string name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: the hue-wheel definition computed with plain integer arithmetic.
  function automatic void model(input logic [23:0] c, output int hue, output int amp);
    int r, g, b, mx, mn, delta, sec, num, f;
    r = int'(c[23:16]);
    g = int'(c[15:8]);
    b = int'(c[7:0]);
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;
    mn = (mn < b) ? mn : b;
    delta = mx - mn;
    if (r == mx) begin
      if (g >= b) begin sec = 0; num = g - b; end
      else        begin sec = 5; num = r - b; end
    end else if (g == mx) begin
      if (r > b)  begin sec = 1; num = g - r; end
      else        begin sec = 2; num = b - r; end
    end else begin
      if (g > r)  begin sec = 3; num = b - g; end
      else        begin sec = 4; num = r - g; end
    end
    if (delta == 0) begin
      sec = 0;
      f = 0;
    end else begin
      f = (num * 1024) / delta;
      if (f > 1023) f = 1023;
    end
    hue = ((sec * 1024 + f) * INV_SIX) / 1024;
    if (hue > 1023) hue = 1023;
    amp = mx * 4 + mx / 64;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.data_v) begin
      if (sb.size() == 0) begin
        check("unexpected_data_v", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_hue"}, int'(bus.noteHue_o), e.hue);
        check({e.name, "_amp"}, int'(bus.noteAmplitude_o), e.amp);
        check({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!bus.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic issue(input logic [23:0] c, input int ehue, input int eamp, input string name);
    exp_t e;
    wait_ready(name);
    bus.start = 1'b1;
    bus.rgb   = c;
    e.hue  = ehue;
    e.amp  = eamp;
    e.due  = cyc + LAT;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.rgb   = 24'($urandom());
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n0, eh, ea, sel;
    logic [7:0] r, g, b;
    exp_t e;

    bus.start = 1'b0;
    bus.rgb   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ready", int'(bus.ready), 1);
    check("reset_data_v", int'(bus.data_v), 0);
    check("reset_hue", int'(bus.noteHue_o), 0);
    check("reset_amp", int'(bus.noteAmplitude_o), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(24'hFF0000, 0, 1023, "red");
    for (int k = 1; k <= LAT; k++) begin
      check("busy_ready", int'(bus.ready), 0);
      @(negedge clk);
    end
    check("idle_ready", int'(bus.ready), 1);
    drain();

    issue(24'h00FF00, 342, 1023, "green");   drain();
    issue(24'h0000FF, 684, 1023, "blue");    drain();
    issue(24'hFF8000, 85, 1023, "orange");   drain();
    issue(24'hFFFF00, 170, 1023, "yellow");  drain();
    issue(24'h808080, 0, 514, "grey");       drain();
    issue(24'h000000, 0, 0, "black");        drain();
    issue(24'hFF0001, 1023, 1023, "hue_clamp"); drain();

    issue(24'h00FF00, 342, 1023, "second_ignored");
    repeat (4) @(negedge clk);
    check("second_start_ready", int'(bus.ready), 0);
    bus.start = 1'b1;
    bus.rgb   = 24'h0000FF;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    wait_ready("held");
    n0 = cyc;
    bus.start = 1'b1;
    bus.rgb   = 24'hFF8000;
    for (int k = 0; k < 3; k++) begin
      e.hue  = 85;
      e.amp  = 1023;
      e.due  = n0 + LAT + 14 * k;
      e.name = "held";
      sb.push_back(e);
    end
    repeat (30) @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (20) @(negedge clk);

    wait_ready("abort");
    n0 = cyc;
    bus.start = 1'b1;
    bus.rgb   = 24'hFFFF00;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < n0 + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", int'(bus.ready), 1);
    check("abort_data_v", int'(bus.data_v), 0);
    check("abort_hue", int'(bus.noteHue_o), 0);
    check("abort_amp", int'(bus.noteAmplitude_o), 0);
    repeat (20) @(negedge clk);
    issue(24'hFF8000, 85, 1023, "after_abort");
    drain();

    for (int i = 0; i < 150; i++) begin
      r = 8'($urandom_range(0, 255));
      g = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 7);
      case (sel)
        0: g = r;
        1: b = g;
        2: b = r;
        3: begin g = r; b = r; end
        4: r = 8'hFF;
        default: ;
      endcase
      model({r, g, b}, eh, ea);
      issue({r, g, b}, eh, ea, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
